// File: rtl/serial_adder_full_adder_1b.sv
// Single-bit full adder: the purely combinational core of the bit-serial adder.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first. Holds the running carry between bits; sum and
// carry-out are Mealy outputs of the current operand bits and the held carry.
module serial_adder #(
  parameter logic CARRY_INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  output logic F,
  output logic Cout
);

  logic c_q;
  logic c_d;
  logic fa_sum;
  logic fa_carry;

  full_adder_1b u_fa (
    .a    (A),
    .b    (B),
    .cin  (c_q),
    .s    (fa_sum),
    .cout (fa_carry)
  );

  // Reset selects CARRY_INIT as the next carry and forces both outputs low.
  // Operand bits are ignored entirely, so X on A/B cannot reach the flop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    F    = 1'b0;
    Cout = 1'b0;
    c_d  = CARRY_INIT;
    if (rst) begin
      F    = fa_sum;
      Cout = fa_carry;
      c_d  = fa_carry;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update together.
  always_ff @(posedge clk) begin
    c_q <= c_d;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: reset masking, plain adds, overflow,
// mid-word reset, combinational behaviour and the CARRY_INIT=1 subtract mode.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  logic A;
  logic B;
  logic F;
  logic Cout;
  logic F_s;
  logic Cout_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .F    (F),
    .Cout (Cout)
  );

  serial_adder #(.CARRY_INIT(1'b1)) dut_sub (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .F    (F_s),
    .Cout (Cout_s)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one operand bit (rst high), check the plain-add instance, clock it in.
  task automatic bit0(input string tag, input logic a, input logic b,
                      input logic exp_f, input logic exp_c);
    rst = 1'b1; A = a; B = b;
    #1;
    check({tag, ".F"}, F, exp_f);
    check({tag, ".Cout"}, Cout, exp_c);
    tick();
  endtask

  // Same for the CARRY_INIT=1 instance.
  task automatic bit1(input string tag, input logic a, input logic b,
                      input logic exp_f, input logic exp_c);
    rst = 1'b1; A = a; B = b;
    #1;
    check({tag, ".F"}, F_s, exp_f);
    check({tag, ".Cout"}, Cout_s, exp_c);
    tick();
  endtask

  task automatic word_reset();
    rst = 1'b0; A = 1'b0; B = 1'b0;
    tick();
  endtask

  initial begin
    // Reset held for two edges with A=B=1: outputs masked throughout.
    rst = 1'b0; A = 1'b1; B = 1'b1;
    #1;
    check("rst_pre.F", F, 1'b0);
    check("rst_pre.Cout", Cout, 1'b0);
    tick();
    check("rst_e1.F", F, 1'b0);
    check("rst_e1.Cout", Cout, 1'b0);
    A = 1'bx; B = 1'bx;
    tick();
    check("rst_e2.F", F, 1'b0);
    check("rst_e2.Cout", Cout, 1'b0);
    check("rst_e2.F_sub", F_s, 1'b0);
    // Release between edges with A=1,B=0: F reveals the loaded carry.
    rst = 1'b1; A = 1'b1; B = 1'b0;
    #1;
    check("rel.F", F, 1'b1);
    check("rel.Cout", Cout, 1'b0);
    check("rel.F_sub", F_s, 1'b0);
    check("rel.Cout_sub", Cout_s, 1'b1);

    // 0101 + 0011 = 1000, final carry 0.
    word_reset();
    bit0("add.b0", 1'b1, 1'b1, 1'b0, 1'b1);
    bit0("add.b1", 1'b0, 1'b1, 1'b0, 1'b1);
    bit0("add.b2", 1'b1, 1'b0, 1'b0, 1'b1);
    bit0("add.b3", 1'b0, 1'b0, 1'b1, 1'b0);

    // 1111 + 0001 overflows; carry 1 is retained in the flop.
    word_reset();
    bit0("ovf.b0", 1'b1, 1'b1, 1'b0, 1'b1);
    bit0("ovf.b1", 1'b1, 1'b0, 1'b0, 1'b1);
    bit0("ovf.b2", 1'b1, 1'b0, 1'b0, 1'b1);
    bit0("ovf.b3", 1'b1, 1'b0, 1'b0, 1'b1);
    A = 1'b0; B = 1'b0;
    #1;
    check("ovf.held.F", F, 1'b1);
    check("ovf.held.Cout", Cout, 1'b0);

    // Mid-word reset with C=1: outputs masked, then carry discarded.
    rst = 1'b0; A = 1'b1; B = 1'b1;
    #1;
    check("mid.rst.F", F, 1'b0);
    check("mid.rst.Cout", Cout, 1'b0);
    tick();
    bit0("mid.after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Combinational: load C=1, then toggle A between edges with B=0.
    bit0("comb.load", 1'b1, 1'b1, 1'b0, 1'b1);
    A = 1'b1; B = 1'b0;
    #1;
    check("comb.a1.F", F, 1'b0);
    check("comb.a1.Cout", Cout, 1'b1);
    A = 1'b0;
    #1;
    check("comb.a0.F", F, 1'b1);
    check("comb.a0.Cout", Cout, 1'b0);
    A = 1'b1;
    #1;
    check("comb.a1b.F", F, 1'b0);
    tick();
    A = 1'b0; B = 1'b0;
    #1;
    check("comb.post.F", F, 1'b1);

    // CARRY_INIT=1: 0110 + ~0010 (=1101) gives 0100, final carry 1.
    word_reset();
    bit1("sub.b0", 1'b0, 1'b1, 1'b0, 1'b1);
    bit1("sub.b1", 1'b1, 1'b0, 1'b0, 1'b1);
    bit1("sub.b2", 1'b1, 1'b1, 1'b1, 1'b1);
    bit1("sub.b3", 1'b0, 1'b1, 1'b0, 1'b1);
    A = 1'b0; B = 1'b0;
    #1;
    check("sub.held.F", F_s, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
